guia_0504: RTL and testbench
============================

GUIA_0504 -- requirements
Module: guia_0504

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of clock cycles each (a,b) vector is held before s_in is sampled; legal range 1..15, and 0 SHALL behave as 1.
REQ-002 The block SHALL have parameter EXPECTED, default 4'b0100, meaning the golden truth table indexed by {a,b}, for s = a AND NOT b.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one full truth-table sweep.
REQ-006 The block SHALL have port a, output, 1 bit: first operand driven to the downstream gate stage.
REQ-007 The block SHALL have port b, output, 1 bit: second operand driven to the downstream gate stage.
REQ-008 The block SHALL have port s_in, input, 1 bit: result returned by the gate stage (combinational path a,b -> s_in).
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-011 The block SHALL have port table_q, output, 4 bits: captured s_in per index {a,b}.
REQ-012 The block SHALL have port mismatch, output, 4 bits: table_q XOR EXPECTED, per index.
REQ-013 The block SHALL have port pass, output, 1 bit: high when the last completed sweep had mismatch == 0.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE, with IDLE as the reset state.
REQ-015 In IDLE, start=1 at a rising edge SHALL move to DRIVE, with idx=0, table_q=0, mismatch=0, pass=0, settle counter=0.
REQ-016 {a,b} SHALL equal idx (a = idx[1], b = idx[0]) in DRIVE and SAMPLE, and SHALL be 0 in IDLE and DONE.
REQ-017 DRIVE SHALL last exactly SETTLE cycles, then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle: at its closing edge, table_q[idx] <= s_in and mismatch[idx] <= s_in ^ EXPECTED[idx].
REQ-019 From SAMPLE, idx<3 SHALL give idx+1 and DRIVE with the settle counter cleared; idx==3 SHALL give DONE; idx SHALL never wrap inside a sweep.
REQ-020 DONE SHALL last one cycle: done=1, pass <= (mismatch==0); then IDLE.
REQ-021 Latency: done SHALL be high in the cycle following 4*(SETTLE+1)+1 rising edges after the start-sampling edge (9 edges for SETTLE=1).
REQ-022 busy SHALL be 1 in DRIVE, SAMPLE and DONE, and 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1; no restart and no queuing.
REQ-024 start held high through DONE SHALL launch a new sweep on the first IDLE edge, so back-to-back sweeps have a one-cycle IDLE gap.
REQ-025 table_q, mismatch and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force IDLE, idx=0, settle counter=0, a=0, b=0, busy=0, done=0, table_q=0, mismatch=0, pass=0.
REQ-027 Reset mid-sweep SHALL abort the sweep with no done pulse; partial results SHALL be discarded.
REQ-028 After rst deasserts, the first start SHALL begin a fresh sweep from idx=0.

Structure
REQ-029 The state enum, the default EXPECTED constant and the table width (4) SHALL live in shared package guia_05_pkg.
REQ-030 The settle counter SHALL be sub-module guia_0504_settle_cnt: 4-bit, with clear and enable inputs and a terminal-count output at SETTLE-1.

Verification
REQ-031 Bench with a real a AND NOT b gate, SETTLE=1, one start pulse -> vectors 00,01,10,11 in order; done pulses on edge 9 after start; table_q=0100, mismatch=0000, pass=1.
REQ-032 Gate replaced by an OR model, SETTLE=1 -> table_q=1110, mismatch=1010, pass=0.
REQ-033 SETTLE=3, one start -> each vector held 3 cycles plus 1 sample cycle; done on edge 17; busy high for 17 cycles.
REQ-034 start pulsed again in the 3rd cycle of a sweep -> ignored; exactly one done; results as in REQ-031.
REQ-035 rst asserted in the 5th cycle of a sweep -> a=b=busy=0 and table_q=0 immediately; no done; the next start gives the REQ-031 result.
REQ-036 start held high continuously -> done pulses every 10 cycles (SETTLE=1) with one IDLE cycle between sweeps.

Source files
------------

// File: rtl/guia_05_pkg.sv
// guia_05_pkg: shared FSM states, table width and golden truth table
package guia_05_pkg;
  localparam int TBL_W = 4;
  localparam logic [TBL_W-1:0] EXPECTED_DEF = 4'b0100;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;
endpackage

// File: rtl/guia_0504_settle_cnt.sv
// guia_0504_settle_cnt: 4-bit settle counter, terminal count at SETTLE-1 (SETTLE=0 acts as 1)
module guia_0504_settle_cnt #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [3:0] LAST = 4'((SETTLE == 0 ? 1 : SETTLE) - 1);
  logic [3:0] cnt_q, cnt_d;
  // clear wins over count
  always_comb cnt_d = clr ? 4'd0 : en ? cnt_q + 4'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == LAST;
endmodule

// File: rtl/guia_0504.sv
// guia_0504: truth-table sweeper driving {a,b} and checking s_in against EXPECTED
module guia_0504
  import guia_05_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter logic [TBL_W-1:0] EXPECTED = EXPECTED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] table_q,
  output logic [TBL_W-1:0] mismatch,
  output logic             pass
);
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [TBL_W-1:0] tbl_d, mm_d;
  logic pass_d, tc;
  guia_0504_settle_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q != DRIVE),
    .en (state_q == DRIVE),
    .tc (tc)
  );
  // next state and result capture; results only change on accepted start or sampling
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = table_q;
    mm_d    = mismatch;
    pass_d  = pass;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        idx_d   = 2'd0;
        tbl_d   = '0;
        mm_d    = '0;
        pass_d  = 1'b0;
      end
      DRIVE: state_d = tc ? SAMPLE : DRIVE;
      SAMPLE: begin
        tbl_d[idx_q] = s_in;
        mm_d[idx_q]  = s_in ^ EXPECTED[idx_q];
        state_d      = idx_q == 2'd3 ? DONE : DRIVE;
        idx_d        = idx_q == 2'd3 ? idx_q : idx_q + 2'd1;
      end
      DONE: begin
        pass_d  = mismatch == '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      table_q  <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      table_q  <= tbl_d;
      mismatch <= mm_d;
      pass     <= pass_d;
    end
  assign {a, b} = (state_q == DRIVE || state_q == SAMPLE) ? idx_q : 2'b00;
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
endmodule

// File: tb/tb_guia_0504.sv
// tb_guia_0504: randomized gate tables checked against an arithmetic sweep timeline model
module tb_guia_0504;
  logic clk = 1'b0, rst = 1'b1, st1 = 1'b0, st3 = 1'b0, sel = 1'b0;
  logic [3:0] tt = 4'b0100;
  logic a1, b1, s1, bz1, dn1, ps1, a3, b3, s3, bz3, dn3, ps3;
  logic [3:0] tq1, mm1, tq3, mm3;
  logic a_o, b_o, busy_o, done_o, pass_o;
  logic [3:0] tq_o, mm_o;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign s1 = tt[{a1, b1}];
  assign s3 = tt[{a3, b3}];
  guia_0504 #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .s_in(s1),
    .busy(bz1), .done(dn1), .table_q(tq1), .mismatch(mm1), .pass(ps1)
  );
  guia_0504 #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .s_in(s3),
    .busy(bz3), .done(dn3), .table_q(tq3), .mismatch(mm3), .pass(ps3)
  );
  always_comb begin
    {a_o, b_o, busy_o, done_o, tq_o, mm_o, pass_o} = sel ?
      {a3, b3, bz3, dn3, tq3, mm3, ps3} : {a1, b1, bz1, dn1, tq1, mm1, ps1};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_start(input logic v);
    if (sel) st3 = v;
    else st1 = v;
  endtask
  // mode 0: single pulse; 1: extra start pulse in third cycle; 2: leave start high at the end
  task automatic sweep(input int s, input int mode);
    int per = 4 * (s + 1);
    logic [3:0] exp_mm = tt ^ 4'b0100;
    set_start(1'b1);
    tick;
    if (mode != 2) set_start(1'b0);
    chk("busy_at_start", busy_o, 1);
    chk("ab_at_start", {a_o, b_o}, 0);
    chk("table_cleared", tq_o, 0);
    chk("pass_cleared", pass_o, 0);
    for (int j = 1; j <= per; j++) begin
      tick;
      if (mode == 1) set_start(j == 2);
      chk("busy_sweep", busy_o, 1);
      chk("done_timing", done_o, j == per);
      chk("ab_vector", {a_o, b_o}, j < per ? j / (s + 1) : 0);
    end
    tick;
    chk("busy_idle", busy_o, 0);
    chk("done_idle", done_o, 0);
    chk("table_q", tq_o, tt);
    chk("mismatch", mm_o, exp_mm);
    chk("pass", pass_o, exp_mm == 4'b0000);
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_busy", bz1, 0);
    chk("rst_ab", {a1, b1}, 0);
    chk("rst_table", tq1, 0);
    chk("rst_pass", ps1, 0);
    chk("rst_busy3", bz3, 0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) begin
      tt = i == 0 ? 4'b0100 : i == 1 ? 4'b1110 : 4'($urandom_range(0, 15));
      sweep(1, 0);
      repeat (3) tick;
      chk("hold_table", tq_o, tt);
      chk("hold_done", done_o, 0);
    end
    tt = 4'b0100;
    sweep(1, 1);
    repeat (12) begin
      tick;
      chk("no_extra_done", done_o, 0);
    end
    tt = 4'b1011;
    set_start(1'b1);
    tick;
    set_start(1'b0);
    repeat (4) tick;
    chk("partial_table", tq_o, 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("arst_ab", {a_o, b_o}, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_table", tq_o, 0);
    chk("arst_mismatch", mm_o, 0);
    tick;
    rst = 1'b0;
    repeat (12) begin
      tick;
      chk("no_done_after_rst", done_o, 0);
    end
    tt = 4'b0100;
    sweep(1, 0);
    sweep(1, 2);
    tt = 4'($urandom_range(0, 15));
    sweep(1, 2);
    sweep(1, 0);
    sel = 1'b1;
    tt = 4'b0100;
    sweep(3, 0);
    tt = 4'($urandom_range(0, 15));
    sweep(3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
